audf_load_ctrl: RTL and testbench

//  Sequences CPU writes into the four AUDF frequency latch banks (8 cell4 bits per channel).

---
 rtl/audf_load_ctrl_pkg.sv | 27 ++
 rtl/audf_wr_fifo.sv | 52 +++++
 rtl/audf_load_ctrl.sv | 135 +++++++++++++
 tb/tb_audf_load_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audf_load_ctrl_pkg.sv
// Shared constants for the AUDF load sequencer: channel count, FSM encodings,
// FIFO entry layout and address decode helpers.
package audf_load_ctrl_pkg;

  localparam int NUM_CH = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_CLEAR   = 3'd4;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } audf_entry_t;

  // AUDF1..AUDF4 sit at the even addresses 0,2,4,6.
  function automatic logic audf_addr_hit(input logic [3:0] addr);
    return (addr[3] == 1'b0) && (addr[0] == 1'b0);
  endfunction

  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/audf_wr_fifo.sv
// Synchronous write FIFO for buffered AUDF writes; a push while full is dropped,
// push and pop on the same edge are both honoured.
module audf_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok;
  logic         pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/audf_load_ctrl.sv
// Sequences buffered CPU writes into the four AUDF latch banks with a
// break-before-make Ld/nLd window. Optional AUDF_READBACK_EN adds shadow readback.
//
// state   | meaning
// IDLE    | waiting for a FIFO entry; pop loads working register and d_out
// SETUP   | ld[ch]=1, all nld high, data settling on d_out
// ARM     | ld[ch]=1, nld[ch]=0; bank captures on the first edge with enp=1
// RELEASE | nld[ch] back high, ld[ch] still high
// CLEAR   | all ld low, then back to IDLE
module audf_load_ctrl
  import audf_load_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enp,
  input  logic       cpu_wr,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_data,
  output logic [7:0] d_out,
  output logic [3:0] ld,
  output logic [3:0] nld,
  output logic       busy,
  output logic       full,
  output logic       ovf
`ifdef AUDF_READBACK_EN
  ,
  input  logic [1:0] rd_ch,
  output logic [7:0] rd_data
`endif
);

  logic [2:0]  state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [7:0]  data_q, data_d;
  logic        ovf_q, ovf_d;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  audf_entry_t wr_entry;
  audf_entry_t head;
  logic [3:0]  sel;

  assign push     = cpu_wr && audf_addr_hit(cpu_addr);
  assign pop      = (state_q == ST_IDLE) && !fifo_empty;
  assign wr_entry = '{ch: cpu_addr[2:1], data: cpu_data};

  audf_wr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     ($bits(audf_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    data_d  = data_q;
    ovf_d   = ovf_q | (push && fifo_full);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_SETUP;
          ch_d    = head.ch;
          data_d  = head.data;
        end
      end
      ST_SETUP:   state_d = ST_ARM;
      ST_ARM:     if (enp) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= 2'd0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode from registered state only, so the window is glitch-free.
  always_comb begin
    sel = ch_onehot(ch_q);
    ld  = 4'b0000;
    nld = 4'b1111;
    case (state_q)
      ST_SETUP, ST_RELEASE: ld = sel;
      ST_ARM: begin
        ld  = sel;
        nld = ~sel;
      end
      default: ;
    endcase
  end

  assign d_out = data_q;
  assign busy  = !fifo_empty || (state_q != ST_IDLE);
  assign full  = fifo_full;
  assign ovf   = ovf_q;

`ifdef AUDF_READBACK_EN
  logic [7:0] shadow_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= 8'h00;
    end else if ((state_q == ST_ARM) && enp) begin
      shadow_q[ch_q] <= data_q;
    end
  end

  assign rd_data = shadow_q[rd_ch];
`endif

endmodule

// File: tb/tb_audf_load_ctrl.sv
// Self-checking bench for audf_load_ctrl: scoreboard of expected loads checked
// against a behavioural model of the latch banks driven by ld/nld/enp/d_out.
module tb_audf_load_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enp;
  logic       cpu_wr;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic [7:0] d_out;
  logic [3:0] ld;
  logic [3:0] nld;
  logic       busy;
  logic       full;
  logic       ovf;
`ifdef AUDF_READBACK_EN
  logic [1:0] rd_ch;
  logic [7:0] rd_data;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [9:0] exp_q [$];
  logic [7:0] bank [4];

  audf_load_ctrl #(.DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .enp      (enp),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .d_out    (d_out),
    .ld       (ld),
    .nld      (nld),
    .busy     (busy),
    .full     (full),
    .ovf      (ovf)
`ifdef AUDF_READBACK_EN
    ,
    .rd_ch    (rd_ch),
    .rd_data  (rd_data)
`endif
  );

  always #5 clk = ~clk;

  // Latch bank model plus window invariants; a capture pops the scoreboard.
  always @(negedge clk) begin
    logic [1:0] c;
    logic [9:0] e;
    if (!reset) begin
      n_assert++;
      if ($countones(ld) > 1 || $countones(~nld) > 1 || ((~nld & ~ld) != 4'b0000)) begin
        n_fail++;
        $display("FAIL window_invariant: ld=%b nld=%b", ld, nld);
      end
      if (enp && ((ld & ~nld) != 4'b0000)) begin
        c = 2'd0;
        for (int i = 0; i < 4; i++) if (ld[i]) c = 2'(i);
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_load: ch=%0d data=%h, expected no load", c, d_out);
        end else begin
          e = exp_q.pop_front();
          if ({c, d_out} !== e) begin
            n_fail++;
            $display("FAIL load_order: got ch=%0d data=%h, expected ch=%0d data=%h",
                     c, d_out, e[9:8], e[7:0]);
          end
        end
        bank[c] = d_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    tick();
    cpu_wr   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_assert++;
    if ({ld, nld, d_out, busy, full, ovf} !== {4'b0000, 4'b1111, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_outputs: ld=%b nld=%b d_out=%h busy=%b full=%b ovf=%b, expected 0000 1111 00 0 0 0",
               ld, nld, d_out, busy, full, ovf);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ignored();
    enp = 1'b1;
    do_write(4'd1, 8'h5A);
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_addr1: busy=%b, expected 0", busy);
    end
    do_write(4'd8, 8'h5B);
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_addr8: busy=%b, expected 0", busy);
    end
    repeat (4) tick();
    n_assert++;
    if ({busy, full, ld} !== {2'b00, 4'b0000}) begin
      n_fail++;
      $display("FAIL ignored_quiet: busy=%b full=%b ld=%b, expected 0 0 0000", busy, full, ld);
    end
  endtask

  task automatic test_single();
    enp = 1'b1;
    exp_q.push_back({2'd1, 8'hA5});
    do_write(4'd2, 8'hA5);
    n_assert++;
    if ({busy, ld} !== {1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_queued: busy=%b ld=%b, expected 1 0000", busy, ld);
    end
    tick();
    n_assert++;
    if ({ld, nld, d_out} !== {4'b0010, 4'b1111, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_setup: ld=%b nld=%b d_out=%h, expected 0010 1111 a5", ld, nld, d_out);
    end
    tick();
    n_assert++;
    if ({ld, nld, d_out} !== {4'b0010, 4'b1101, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_arm: ld=%b nld=%b d_out=%h, expected 0010 1101 a5", ld, nld, d_out);
    end
    tick();
    n_assert++;
    if ({ld, nld, d_out, bank[1]} !== {4'b0010, 4'b1111, 8'hA5, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_release: ld=%b nld=%b d_out=%h bank1=%h, expected 0010 1111 a5 a5",
               ld, nld, d_out, bank[1]);
    end
    tick();
    n_assert++;
    if ({ld, nld, d_out, busy} !== {4'b0000, 4'b1111, 8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL single_clear: ld=%b nld=%b d_out=%h busy=%b, expected 0000 1111 a5 1",
               ld, nld, d_out, busy);
    end
    tick();
    n_assert++;
    if ({busy, exp_q.size() == 0} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b pending=%0d, expected 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_enp_gate();
    enp = 1'b1;
    exp_q.push_back({2'd0, 8'h3C});
    do_write(4'd0, 8'h3C);
    enp = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      n_assert++;
      if ({ld, nld, bank[0]} !== {4'b0001, 4'b1110, 8'h00}) begin
        n_fail++;
        $display("FAIL enp_hold[%0d]: ld=%b nld=%b bank0=%h, expected 0001 1110 00",
                 i, ld, nld, bank[0]);
      end
      tick();
    end
    enp = 1'b1;
    tick();
    n_assert++;
    if ({ld, nld, bank[0]} !== {4'b0001, 4'b1111, 8'h3C}) begin
      n_fail++;
      $display("FAIL enp_capture: ld=%b nld=%b bank0=%h, expected 0001 1111 3c", ld, nld, bank[0]);
    end
    wait_idle(20, "enp_gate");
  endtask

  task automatic test_overflow();
    enp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back({2'd2, 8'(8'h10 + i)});
      cpu_wr   = 1'b1;
      cpu_addr = 4'd4;
      cpu_data = 8'(8'h10 + i);
      tick();
      if (i == 4) begin
        n_assert++;
        if ({full, ovf} !== 2'b10) begin
          n_fail++;
          $display("FAIL ovf_at_depth: full=%b ovf=%b, expected 1 0", full, ovf);
        end
      end
    end
    cpu_wr = 1'b0;
    n_assert++;
    if ({full, ovf, busy, ld} !== {3'b111, 4'b0100}) begin
      n_fail++;
      $display("FAIL ovf_set: full=%b ovf=%b busy=%b ld=%b, expected 1 1 1 0100", full, ovf, busy, ld);
    end
    enp = 1'b1;
    wait_idle(100, "overflow");
    n_assert++;
    if ({bank[2], full, ovf, exp_q.size() == 0} !== {8'h14, 3'b011}) begin
      n_fail++;
      $display("FAIL ovf_drain: bank2=%h full=%b ovf=%b pending=%0d, expected 14 0 1 0",
               bank[2], full, ovf, exp_q.size());
    end
  endtask

  task automatic test_ordering();
    enp = 1'b1;
    exp_q.push_back({2'd0, 8'h11});
    exp_q.push_back({2'd3, 8'h22});
    exp_q.push_back({2'd0, 8'h33});
    do_write(4'd0, 8'h11);
    do_write(4'd6, 8'h22);
    do_write(4'd0, 8'h33);
    wait_idle(50, "ordering");
    n_assert++;
    if ({bank[0], bank[3], exp_q.size() == 0} !== {8'h33, 8'h22, 1'b1}) begin
      n_fail++;
      $display("FAIL ordering_final: bank0=%h bank3=%h pending=%0d, expected 33 22 0",
               bank[0], bank[3], exp_q.size());
    end
`ifdef AUDF_READBACK_EN
    rd_ch = 2'd0;
    #1;
    n_assert++;
    if (rd_data !== 8'h33) begin
      n_fail++;
      $display("FAIL readback_ch0: rd_data=%h, expected 33", rd_data);
    end
    rd_ch = 2'd3;
    #1;
    n_assert++;
    if (rd_data !== 8'h22) begin
      n_fail++;
      $display("FAIL readback_ch3: rd_data=%h, expected 22", rd_data);
    end
`endif
  endtask

  task automatic test_reset_arm();
    enp = 1'b0;
    exp_q.push_back({2'd1, 8'h77});
    do_write(4'd2, 8'h77);
    tick();
    tick();
    n_assert++;
    if ({ld, nld} !== {4'b0010, 4'b1101}) begin
      n_fail++;
      $display("FAIL rst_arm_entry: ld=%b nld=%b, expected 0010 1101", ld, nld);
    end
    reset = 1'b1;
    tick();
    n_assert++;
    if ({ld, nld, d_out, busy, full, ovf} !== {4'b0000, 4'b1111, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL rst_arm_outputs: ld=%b nld=%b d_out=%h busy=%b full=%b ovf=%b, expected 0000 1111 00 0 0 0",
               ld, nld, d_out, busy, full, ovf);
    end
    reset = 1'b0;
    exp_q.delete();
    enp = 1'b1;
    repeat (5) tick();
    n_assert++;
    if ({busy, ld, bank[1]} !== {1'b0, 4'b0000, 8'hA5}) begin
      n_fail++;
      $display("FAIL rst_arm_no_retry: busy=%b ld=%b bank1=%h, expected 0 0000 a5", busy, ld, bank[1]);
    end
`ifdef AUDF_READBACK_EN
    rd_ch = 2'd0;
    #1;
    n_assert++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL readback_reset: rd_data=%h, expected 00", rd_data);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) bank[i] = 8'h00;
    reset    = 1'b1;
    enp      = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 4'd0;
    cpu_data = 8'h00;
`ifdef AUDF_READBACK_EN
    rd_ch    = 2'd0;
`endif
    test_reset();
    test_ignored();
    test_single();
    test_enp_gate();
    test_overflow();
    test_ordering();
    test_reset_arm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
